// File: rtl/tile_scheduler_if.sv
// rtl/tile_scheduler_if.sv - command handshake and tile_processor control bundle for tile_scheduler
interface tile_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_rows_m1;
    logic [2:0] cmd_cols_m1;
    logic       tp_start;
    logic [2:0] tp_tile_i;
    logic [2:0] tp_tile_j;
    logic [2:0] tp_op_code;
    logic       tp_done;

    modport master (
        output cmd_valid, cmd_op, cmd_rows_m1, cmd_cols_m1, tp_done,
        input  cmd_ready, tp_start, tp_tile_i, tp_tile_j, tp_op_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rows_m1, cmd_cols_m1, tp_done,
        output cmd_ready, tp_start, tp_tile_i, tp_tile_j, tp_op_code
    );
endinterface

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - row-major tile sequencer driving one tile_processor
// Optional per-tile watchdog enabled by defining TILE_SCHED_WATCHDOG_EN.
module tile_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    tile_scheduler_if.slave     bus,
    input  logic                abort,
    output logic                busy,
    output logic                sched_done,
    output logic                err,
    output logic [6:0]          tiles_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADVANCE} state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d, rows_q, rows_d, cols_q, cols_d;
    logic [2:0] ti_q, ti_d, tj_q, tj_d;
    logic       start_q, start_d, ready_q, ready_d, busy_q, busy_d;
    logic       sdone_q, sdone_d, err_q, err_d;
    logic [6:0] cnt_q, cnt_d;
    logic       done_q;
    logic       done_edge;

    if ($clog2(TIMEOUT_CYCLES + 1) > TO_W) begin : g_to_w_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

`ifdef TILE_SCHED_WATCHDOG_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`endif

    // A level held over from the previous tile never looks like a new edge.
    assign done_edge = bus.tp_done & ~done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            rows_q  <= '0;
            cols_q  <= '0;
            ti_q    <= '0;
            tj_q    <= '0;
            start_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            sdone_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rows_q  <= rows_d;
            cols_q  <= cols_d;
            ti_q    <= ti_d;
            tj_q    <= tj_d;
            start_q <= start_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            sdone_q <= sdone_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            done_q  <= bus.tp_done;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rows_d  = rows_q;
        cols_d  = cols_q;
        ti_d    = ti_q;
        tj_d    = tj_q;
        start_d = 1'b0;
        ready_d = ready_q;
        busy_d  = busy_q;
        sdone_d = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!abort && bus.cmd_valid && ready_q) begin
                    cnt_d = '0;
                    if (bus.cmd_op > 3'd4) begin
                        err_d = 1'b1;
                    end else begin
                        op_d    = bus.cmd_op;
                        rows_d  = bus.cmd_rows_m1;
                        cols_d  = bus.cmd_cols_m1;
                        ti_d    = '0;
                        tj_d    = '0;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        start_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (done_edge) begin
                    cnt_d   = (cnt_q == 7'd64) ? cnt_q : cnt_q + 7'd1;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                if (tj_q < cols_q) begin
                    tj_d    = tj_q + 3'd1;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else if (ti_q < rows_q) begin
                    tj_d    = '0;
                    ti_d    = ti_q + 3'd1;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end else begin
                    sdone_d = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef TILE_SCHED_WATCHDOG_EN
        wd_d    = (state_q == WAIT) ? wd_q + TO_W'(1) : '0;
        timeout = (state_q == WAIT) && !done_edge && (wd_q == TO_W'(TIMEOUT_CYCLES - 1));
        if (timeout) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = IDLE;
        end
`endif
        // Abort wins over every in-flight event, including a final sched_done.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            start_d = 1'b0;
            sdone_d = 1'b0;
            err_d   = 1'b0;
            cnt_d   = cnt_q;
        end
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.tp_start   = start_q;
    assign bus.tp_tile_i  = ti_q;
    assign bus.tp_tile_j  = tj_q;
    assign bus.tp_op_code = op_q;
    assign busy           = busy_q;
    assign sched_done     = sdone_q;
    assign err            = err_q;
    assign tiles_done     = cnt_q;
endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - self-checking bench for tile_scheduler
module tb_tile_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       abort = 1'b0;
    logic       busy, sched_done, err;
    logic [6:0] tiles_done;
    int         n_chk = 0;
    int         n_err = 0;

    tile_scheduler_if bus ();

    tile_scheduler #(.TIMEOUT_CYCLES(16), .TO_W(13)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .abort      (abort),
        .busy       (busy),
        .sched_done (sched_done),
        .err        (err),
        .tiles_done (tiles_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Reference: tiles visited row-major, j inner; each tile counted on a fresh tp_done rise.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rm1, input logic [2:0] cm1,
                           input int lat, input bit hold, input int abort_tile, input int reset_tile);
        int qi[$];
        int qj[$];
        int ntiles, w, lat_k;
        for (int i = 0; i <= int'(rm1); i++)
            for (int j = 0; j <= int'(cm1); j++) begin
                qi.push_back(i);
                qj.push_back(j);
            end
        ntiles = qi.size();
        bus.cmd_op      = op;
        bus.cmd_rows_m1 = rm1;
        bus.cmd_cols_m1 = cm1;
        bus.cmd_valid   = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", bus.cmd_ready, 0);
        for (int k = 0; k < ntiles; k++) begin
            w = 0;
            while (bus.tp_start !== 1'b1 && w < 20) begin
                tick;
                w++;
            end
            chk("start_seen", bus.tp_start, 1);
            if (bus.tp_start !== 1'b1) return;
            chk("start_latency", w, 0);
            chk("tile_i", bus.tp_tile_i, qi[k]);
            chk("tile_j", bus.tp_tile_j, qj[k]);
            chk("op_code", bus.tp_op_code, op);
            tick;
            chk("start_one_cycle", bus.tp_start, 0);
            if (k == abort_tile) begin
                tick;
                tick;
                abort = 1'b1;
                tick;
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_ready", bus.cmd_ready, 1);
                chk("abort_start", bus.tp_start, 0);
                chk("abort_tiles_held", tiles_done, k);
                chk("abort_err", err, 0);
                tick;
                chk("abort_no_sdone", sched_done, 0);
                return;
            end
            if (k == reset_tile) begin
                tick;
                #2 rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_ready", bus.cmd_ready, 1);
                chk("rst_tiles", tiles_done, 0);
                chk("rst_tile_j", bus.tp_tile_j, 0);
                chk("rst_op", bus.tp_op_code, 0);
                chk("rst_sdone", sched_done, 0);
                tick;
                rst_n = 1'b1;
                tick;
                return;
            end
            lat_k = (lat > 0) ? lat : int'($urandom_range(1, 8));
            for (int d = 1; d < lat_k; d++) tick;
            if (hold && k > 0) begin
                chk("hold_not_counted", tiles_done, k);
                bus.tp_done = 1'b0;
                tick;
            end
            bus.tp_done = 1'b1;
            tick;
            if (!hold) bus.tp_done = 1'b0;
            chk("tiles_done_inc", tiles_done, (k + 1 > 64) ? 64 : k + 1);
            if (k == ntiles - 1) begin
                chk("sdone_not_early", sched_done, 0);
                tick;
                chk("sdone_pulse", sched_done, 1);
                chk("sdone_busy", busy, 0);
                chk("sdone_ready", bus.cmd_ready, 1);
                chk("sdone_tiles", tiles_done, ntiles);
                tick;
                chk("sdone_one_cycle", sched_done, 0);
            end else begin
                tick;
            end
        end
        bus.tp_done = 1'b0;
        tick;
    endtask

    initial begin
        logic err_seen;
        bus.cmd_valid   = 1'b0;
        bus.cmd_op      = '0;
        bus.cmd_rows_m1 = '0;
        bus.cmd_cols_m1 = '0;
        bus.tp_done     = 1'b0;
        repeat (3) tick;
        chk("reset_ready", bus.cmd_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_start", bus.tp_start, 0);
        chk("reset_tiles", tiles_done, 0);
        chk("reset_err", err, 0);
        chk("reset_sdone", sched_done, 0);
        rst_n = 1'b1;
        tick;

        run_cmd(3'd0, 3'd1, 3'd2, 10, 1'b0, -1, -1);

        bus.cmd_op    = 3'd6;
        bus.cmd_valid = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        chk("illegal_err", err, 1);
        chk("illegal_busy", busy, 0);
        chk("illegal_ready", bus.cmd_ready, 1);
        chk("illegal_start", bus.tp_start, 0);
        chk("illegal_tiles", tiles_done, 0);
        tick;
        chk("illegal_err_one_cycle", err, 0);
        chk("illegal_no_start", bus.tp_start, 0);

        run_cmd(3'd1, 3'd0, 3'd1, 6, 1'b1, -1, -1);

        run_cmd(3'd3, 3'd1, 3'd1, 5, 1'b0, 2, -1);
        run_cmd(3'd4, 3'd0, 3'd0, 4, 1'b0, -1, -1);

        bus.cmd_op      = 3'd0;
        bus.cmd_rows_m1 = 3'd0;
        bus.cmd_cols_m1 = 3'd0;
        bus.cmd_valid   = 1'b1;
        tick;
        bus.cmd_valid = 1'b0;
        chk("wd_start", bus.tp_start, 1);
        tick;
        err_seen = 1'b0;
`ifdef TILE_SCHED_WATCHDOG_EN
        for (int k = 0; k < 15; k++) begin
            tick;
            err_seen |= err;
        end
        tick;
        chk("wd_no_early_err", err_seen, 0);
        chk("wd_err", err, 1);
        chk("wd_busy", busy, 0);
        chk("wd_ready", bus.cmd_ready, 1);
        chk("wd_tiles_held", tiles_done, 0);
        tick;
        chk("wd_err_one_cycle", err, 0);
        chk("wd_no_sdone", sched_done, 0);
`else
        for (int k = 0; k < 40; k++) begin
            tick;
            err_seen |= err;
        end
        chk("nowd_no_err", err_seen, 0);
        chk("nowd_still_busy", busy, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("nowd_abort_busy", busy, 0);
`endif

        run_cmd(3'd2, 3'd1, 3'd1, 5, 1'b0, -1, 1);
        run_cmd(3'd0, 3'd0, 3'd0, 3, 1'b0, -1, -1);

        for (int r = 0; r < 5; r++)
            run_cmd(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 0, 1'b0, -1, -1);

        run_cmd(3'd1, 3'd7, 3'd7, 1, 1'b0, -1, -1);
        tick;
        chk("saturated_retained", tiles_done, 64);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
